fdivsqrt_remres: RTL and testbench
==================================

# fdivsqrt_remres

Multi-cycle remainder-resolution unit consuming the final state of the radix-2 divide/sqrt recurrence: redundant partial remainder (WS, WC), on-the-fly quotient pair (U, UM), and divisor D. It resolves the remainder to non-redundant form chunk-by-chunk, with carries held across cycles. From that result it determines the remainder sign and selects U or UM as the final quotient. It computes the sticky bit from the corrected remainder and returns results over a valid/ready handshake to the rounding/postprocessing stage.

## Interface
- DIVB, default 59: recurrence fraction width; remainder width W = DIVB+4, quotient width DIVB+1.
- CHUNK, default 16: bits resolved per cycle; NCHUNK = ceil((DIVB+4)/CHUNK), 4 at defaults.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  operands valid.
- InReady  out  1  unit can accept operands.
- WS, WC  in  DIVB+4  redundant remainder sum/carry.
- D  in  DIVB+4  divisor as aligned in the recurrence (positive).
- U, UM  in  DIVB+1  quotient and quotient-minus-one-ulp.
- Flush  in  1  abort current operation.
- OutValid  out  1  results valid.
- OutReady  in  1  consumer accepts results.
- Quot  out  DIVB+1  selected quotient.
- RemNeg  out  1  resolved remainder negative.
- Sticky  out  1  corrected remainder nonzero.

## Operation
- States: IDLE, ADD, DONE. Reset state: IDLE. Reset values: InReady=1 (combinational from IDLE), OutValid=0, Quot=0, RemNeg=0, Sticky=0, chunk index=0, carries=0.
- IDLE: InReady=1. On InValid&InReady, latch WS, WC, D, U, UM. Clear idx, c1, c2, z1 and z2 (z1=z2=1), then go to ADD.
- ADD: each cycle, for chunk k=idx (bits [k*CHUNK +: CHUNK], top chunk truncated to width W):
  - s1 = WS_k + WC_k + c1 gives chunk of W; c1 takes 1 bit of carry-out.
  - s2 = WS_k + WC_k + D_k + c2 gives chunk of W+D; c2 takes 2 bits of carry-out (range 0..2).
  - z1 &= (s1==0); z2 &= (s2==0).
  - On the last chunk, record the sign as bit DIVB+3 of W (modulo 2^(DIVB+4)) and go to DONE. Otherwise increment idx.
- DONE: OutValid=1.
  - RemNeg = sign.
  - Quot = RemNeg ? UM : U.
  - Sticky = RemNeg ? ~z2 : ~z1.
  - Outputs stay registered and stable while OutValid&~OutReady.
  - On OutReady, go to IDLE. The unit does not accept new operands in the same cycle (InReady=0 in DONE).
- Flush: next state is IDLE from any state, and OutValid drops. Flush overrides a same-cycle accept and a same-cycle output handshake; the handshake does not complete. The Quot, RemNeg and Sticky registers keep their last values.
- All arithmetic is modulo chunk width. Bits above W are discarded. D is never negated.
- Both InReady and OutValid are decoded from state only, with no combinational path from InValid or OutReady.

## Timing
- The accept edge is edge 0. Edges 1..NCHUNK process chunks 0..NCHUNK-1. OutValid is high from edge NCHUNK, i.e. 4 cycles after accept at defaults.
- The minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK ADD edges, output handshake edge, and a return to IDLE.
- Reset is asynchronous. Asserting it mid-ADD or mid-DONE forces IDLE and the reset values immediately, without waiting for clk. After deassertion, operation resumes on the first rising edge.
- Flush takes effect at the next rising edge. In that cycle InReady reads 0 unless the unit is already in IDLE.

## Test plan
- WS=5, WC=3, D=0x10, U=0x100, UM=0x0FF -> 4 cycles after accept: OutValid=1, Quot=0x100, RemNeg=0, Sticky=1.
- WS=WC=0, U=0x2A -> Quot=0x2A, RemNeg=0, Sticky=0.
- WS=-16 (all ones with low nibble 0), WC=0, D=16, U=0x80, UM=0x7F -> RemNeg=1, Quot=0x7F, Sticky=0; checks carry ripple through all 4 chunks. Repeat with WS=-8 -> Sticky=1.
- Cross-chunk carry: WS=0x0000FFFF, WC=1 -> RemNeg=0, Sticky=1. W=0x10000 is correctly resolved across the chunk 0/1 boundary.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> OutValid, Quot, RemNeg and Sticky are stable, and InReady=0 throughout. Raising OutReady gives IDLE and InReady=1 the next cycle.
- Flush at the second ADD cycle -> IDLE next edge with OutValid never asserted. A new accept then completes with correct results. Asynchronous reset pulse mid-DONE -> OutValid=0 with no clock edge required.

Source files
------------

// File: rtl/fdivsqrt_remres.sv
// rtl/fdivsqrt_remres.sv - multi-cycle remainder resolution, quotient select and sticky for radix-2 div/sqrt
//
// Resolves the redundant partial remainder (WS + WC) and the corrected remainder
// (WS + WC + D) one CHUNK-bit slice per cycle. Each sum keeps its own carry between
// cycles. The sign of the resolved remainder selects U or UM, and the zero flag of
// the matching sum gives the sticky bit.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   InValid / InReady  operand handshake (InReady decoded from state only)
//   WS, WC             redundant remainder sum/carry, DIVB+4 bits
//   D                  positive divisor as aligned in the recurrence, DIVB+4 bits
//   U, UM              quotient and quotient minus one ulp, DIVB+1 bits
//   Flush              abort; forces IDLE at the next rising edge
//   OutValid / OutReady result handshake (OutValid decoded from state only)
//   Quot, RemNeg, Sticky registered results
module fdivsqrt_remres #(
    parameter int DIVB  = 59,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [DIVB+3:0] WS,
    input  logic [DIVB+3:0] WC,
    input  logic [DIVB+3:0] D,
    input  logic [DIVB:0]   U,
    input  logic [DIVB:0]   UM,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [DIVB:0]   Quot,
    output logic            RemNeg,
    output logic            Sticky
);

    localparam int W        = DIVB + 4;
    localparam int NCHUNK   = (W + CHUNK - 1) / CHUNK;
    localparam int EXTW     = NCHUNK * CHUNK;
    localparam int TOP_BITS = W - (NCHUNK - 1) * CHUNK;
    localparam int IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Valid bits of the top chunk. Bits above W only ever hold carry-out, so they are
    // excluded from the zero tests.
    localparam logic [CHUNK-1:0] TOP_MASK = {CHUNK{1'b1}} >> (CHUNK - TOP_BITS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state, next_state;
    logic [EXTW-1:0]   ws_q, wc_q, d_q;
    logic [DIVB:0]     u_q, um_q;
    logic [IDXW-1:0]   idx;
    logic              c1;
    logic [1:0]        c2;
    logic              z1, z2;

    logic [CHUNK-1:0]  ws_k, wc_k, d_k, mask;
    logic [CHUNK:0]    s1_full;
    logic [CHUNK+1:0]  s2_full;
    logic              last, z1_next, z2_next, sign;

    always_comb begin
        ws_k    = ws_q[idx*CHUNK +: CHUNK];
        wc_k    = wc_q[idx*CHUNK +: CHUNK];
        d_k     = d_q[idx*CHUNK +: CHUNK];
        last    = (idx == IDXW'(NCHUNK - 1));
        mask    = last ? TOP_MASK : {CHUNK{1'b1}};
        s1_full = {1'b0, ws_k} + {1'b0, wc_k} + {{CHUNK{1'b0}}, c1};
        s2_full = {2'b00, ws_k} + {2'b00, wc_k} + {2'b00, d_k} + {{CHUNK{1'b0}}, c2};
        z1_next = z1 & ((s1_full[CHUNK-1:0] & mask) == '0);
        z2_next = z2 & ((s2_full[CHUNK-1:0] & mask) == '0);
        // Only meaningful on the last chunk: bit W-1 of the resolved remainder.
        sign    = s1_full[TOP_BITS-1];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (InValid) next_state = ADD;
            ADD:     if (last) next_state = DONE;
            DONE:    if (OutReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (Flush) next_state = IDLE;
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ws_q   <= '0;
            wc_q   <= '0;
            d_q    <= '0;
            u_q    <= '0;
            um_q   <= '0;
            idx    <= '0;
            c1     <= 1'b0;
            c2     <= 2'b00;
            z1     <= 1'b1;
            z2     <= 1'b1;
            Quot   <= '0;
            RemNeg <= 1'b0;
            Sticky <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && InValid && !Flush) begin
                ws_q <= EXTW'(WS);
                wc_q <= EXTW'(WC);
                d_q  <= EXTW'(D);
                u_q  <= U;
                um_q <= UM;
                idx  <= '0;
                c1   <= 1'b0;
                c2   <= 2'b00;
                z1   <= 1'b1;
                z2   <= 1'b1;
            end else if (state == ADD && !Flush) begin
                c1  <= s1_full[CHUNK];
                c2  <= s2_full[CHUNK+1:CHUNK];
                z1  <= z1_next;
                z2  <= z2_next;
                idx <= idx + 1'b1;
                if (last) begin
                    RemNeg <= sign;
                    Quot   <= sign ? um_q : u_q;
                    Sticky <= sign ? ~z2_next : ~z1_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fdivsqrt_remres.sv
// tb/tb_fdivsqrt_remres.sv - scoreboard bench for fdivsqrt_remres
module tb_fdivsqrt_remres;

    localparam int DIVB = 59;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, out_ready, flush;
    logic            in_ready, out_valid;
    logic [DIVB+3:0] ws, wc, d;
    logic [DIVB:0]   u, um;
    logic [DIVB:0]   quot;
    logic            rem_neg, sticky;

    typedef struct packed {
        logic [DIVB:0] quot;
        logic          neg;
        logic          sticky;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fdivsqrt_remres #(.DIVB(DIVB), .CHUNK(16)) dut (
        .clk(clk), .reset(rst),
        .InValid(in_valid), .InReady(in_ready),
        .WS(ws), .WC(wc), .D(d), .U(u), .UM(um),
        .Flush(flush),
        .OutValid(out_valid), .OutReady(out_ready),
        .Quot(quot), .RemNeg(rem_neg), .Sticky(sticky)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed on the edge following a cycle with OutValid & OutReady.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("quot", 64'(quot), 64'(e.quot));
                    check("rem_neg", 64'(rem_neg), 64'(e.neg));
                    check("sticky", 64'(sticky), 64'(e.sticky));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, push its expected result, and check the accept-to-OutValid latency.
    task automatic issue(input logic [DIVB+3:0] a_ws, input logic [DIVB+3:0] a_wc,
                         input logic [DIVB+3:0] a_d, input logic [DIVB:0] a_u,
                         input logic [DIVB:0] a_um, input logic [DIVB:0] e_q,
                         input logic e_neg, input logic e_st);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        ws = a_ws; wc = a_wc; d = a_d; u = a_u; um = a_um;
        in_valid = 1'b1;
        e.quot = e_q; e.neg = e_neg; e.sticky = e_st;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'd4);
    endtask

    initial begin
        logic [DIVB:0] hq;
        logic          hn, hs;
        bit            stable;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        ws = '0; wc = '0; d = '0; u = '0; um = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quot", 64'(quot), 64'd0);
        check("rst_rem_neg", 64'(rem_neg), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        rst = 1'b0;
        tick();

        issue(63'd5, 63'd3, 63'h10, 60'h100, 60'h0FF, 60'h100, 1'b0, 1'b1);
        tick();
        issue(63'd0, 63'd0, 63'h10, 60'h2A, 60'h29, 60'h2A, 1'b0, 1'b0);
        tick();
        issue(63'h7FFF_FFFF_FFFF_FFF0, 63'd0, 63'd16, 60'h80, 60'h7F, 60'h7F, 1'b1, 1'b0);
        tick();
        issue(63'h7FFF_FFFF_FFFF_FFF8, 63'd0, 63'd16, 60'h80, 60'h7F, 60'h7F, 1'b1, 1'b1);
        tick();
        issue(63'h0000_FFFF, 63'd1, 63'd16, 60'h55, 60'h54, 60'h55, 1'b0, 1'b1);
        tick();

        // Backpressure: results hold while OutReady is low.
        out_ready = 1'b0;
        issue(63'h7FFF_FFFF_FFFF_FFF0, 63'd0, 63'd8, 60'h33, 60'h32, 60'h32, 1'b1, 1'b1);
        hq = quot; hn = rem_neg; hs = sticky;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!out_valid || in_ready || quot !== hq || rem_neg !== hn || sticky !== hs)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Flush during the second ADD cycle.
        ws = 63'd7; wc = 63'd1; d = 63'd16; u = 60'h11; um = 60'h10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        check("flush_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_idle", 64'(in_ready), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stable = 1'b0;
            tick();
        end
        check("flush_no_out_valid", 64'(stable), 64'd1);
        issue(63'd7, 63'd1, 63'd16, 60'h11, 60'h10, 60'h11, 1'b0, 1'b1);
        tick();

        // Asynchronous reset in DONE, applied between clock edges.
        out_ready = 1'b0;
        issue(63'd9, 63'd0, 63'd16, 60'h44, 60'h43, 60'h44, 1'b0, 1'b1);
        void'(sb.pop_back());
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_quot", 64'(quot), 64'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        issue(63'h7FFF_FFFF_FFFF_FFF0, 63'd0, 63'd16, 60'h80, 60'h7F, 60'h7F, 1'b1, 1'b0);
        tick();
        tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
